// File: rtl/dmem_responder.sv
// dmem_responder: RV64 load/store responder with sign/zero-extended loads, byte-masked stores and programmable latency
module dmem_responder #(
  parameter int              XLEN      = 64,
  parameter logic [XLEN-1:0] BASE_ADDR = 64'h80000000,
  parameter int              DEPTH     = 8192,
  parameter int              LATENCY   = 1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic [XLEN-1:0] req_addr,
  input  logic [XLEN-1:0] req_wdata,
  input  logic            req_wr,
  input  logic [2:0]      req_op,
  output logic            resp_valid,
  input  logic            resp_ready,
  output logic [XLEN-1:0] resp_rdata,
  output logic            resp_err
);
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] WAIT = 2'd1;
  localparam logic [1:0] RESP = 2'd2;
  localparam int IW = $clog2(DEPTH);
  localparam int CW = LATENCY > 1 ? $clog2(LATENCY) : 1;
  localparam logic [XLEN:0] END_ADDR = {1'b0, BASE_ADDR} + (XLEN+1)'(DEPTH) * (XLEN+1)'(8);
  logic [1:0]      state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [XLEN-1:0] addr_q, addr_d, wdata_q, wdata_d;
  logic            wr_q, wr_d, err_q, err_d;
  logic [2:0]      op_q, op_d;
  logic [XLEN-1:0] rword_q;
  logic [XLEN-1:0] mem [DEPTH];
  logic            idle, go_resp;
  logic [XLEN-1:0] t_addr, t_wdata, t_wsh;
  logic            t_wr, t_err, misal, oor, ill;
  logic [2:0]      t_op, t_off;
  logic [3:0]      t_sz;
  logic [IW-1:0]   t_idx;
  logic [7:0]      t_mask;
  logic [XLEN-1:0] sh, ext;
  assign idle = state_q == IDLE;
  // Decode the live request while idle, the captured one afterwards, so both latency paths share one decoder
  always_comb begin
    t_addr  = idle ? req_addr : addr_q;
    t_wdata = idle ? req_wdata : wdata_q;
    t_wr    = idle ? req_wr : wr_q;
    t_op    = idle ? req_op : op_q;
    t_sz    = 4'd1 << t_op[1:0];
    t_off   = t_addr[2:0];
    misal   = |(t_off & (t_sz[2:0] - 3'd1));
    oor     = (t_addr < BASE_ADDR) || ({1'b0, t_addr} + (XLEN+1)'(t_sz) > END_ADDR);
    ill     = (t_op == 3'b111) || (t_wr && t_op[2]);
    t_err   = misal | oor | ill;
    t_idx   = IW'((t_addr - BASE_ADDR) >> 3);
    t_mask  = (t_op[1:0] == 2'd3 ? 8'hFF : t_op[1:0] == 2'd2 ? 8'h0F : t_op[1:0] == 2'd1 ? 8'h03 : 8'h01) << t_off;
    t_wsh   = t_wdata << {t_off, 3'b000};
  end
  // Next state, latency countdown and request capture; go_resp marks the edge entering RESP
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    wr_d    = wr_q;
    op_d    = op_q;
    err_d   = err_q;
    go_resp = 1'b0;
    if (idle && req_valid) begin
      addr_d  = req_addr;
      wdata_d = req_wdata;
      wr_d    = req_wr;
      op_d    = req_op;
      err_d   = t_err;
      cnt_d   = CW'(LATENCY - 1);
      state_d = LATENCY == 1 ? RESP : WAIT;
      go_resp = LATENCY == 1;
    end else if (state_q == WAIT) begin
      cnt_d   = cnt_q - CW'(1);
      state_d = cnt_q == '0 ? RESP : WAIT;
      go_resp = cnt_q == '0;
    end else if (state_q == RESP && resp_ready) begin
      state_d = IDLE;
    end
    go_resp = go_resp && rst_n;
  end
  // Control state; reset drops any transaction in flight
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end
  // Captured request fields; outputs are gated by state so these need no reset
  always_ff @(posedge clk) begin
    addr_q  <= addr_d;
    wdata_q <= wdata_d;
    wr_q    <= wr_d;
    op_q    <= op_d;
    err_q   <= err_d;
  end
  // Synchronous array: word read and byte-masked store commit on the edge entering RESP
  always_ff @(posedge clk) begin
    if (go_resp) rword_q <= mem[t_idx];
    if (go_resp && t_wr && !t_err)
      for (int b = 0; b < 8; b++)
        if (t_mask[b]) mem[t_idx][b*8 +: 8] <= t_wsh[b*8 +: 8];
  end
  // Align the read word to the access offset, then sign- or zero-extend to the access size
  always_comb begin
    sh  = rword_q >> {addr_q[2:0], 3'b000};
    ext = op_q[1:0] == 2'd3 ? sh :
          op_q[1:0] == 2'd2 ? {{(XLEN-32){~op_q[2] & sh[31]}}, sh[31:0]} :
          op_q[1:0] == 2'd1 ? {{(XLEN-16){~op_q[2] & sh[15]}}, sh[15:0]} :
                              {{(XLEN-8){~op_q[2] & sh[7]}}, sh[7:0]};
  end
  assign req_ready  = idle;
  assign resp_valid = state_q == RESP;
  assign resp_err   = resp_valid && err_q;
  assign resp_rdata = (resp_valid && !err_q && !wr_q) ? ext : '0;
endmodule

// File: tb/tb_dmem_responder.sv
// tb_dmem_responder: scoreboard bench for dmem_responder with directed vectors and a byte-array reference model
module tb_dmem_responder;
  localparam int          LAT   = 4;
  localparam logic [63:0] BASE  = 64'h80000000;
  localparam int          BYTES = 8192 * 8;
  typedef struct {
    logic [63:0] data;
    logic        err;
    int          acc;
  } exp_t;
  logic        clk = 1'b0, rst_n = 1'b0, req_valid = 1'b0, req_wr = 1'b0, resp_ready = 1'b1;
  logic [63:0] req_addr = '0, req_wdata = '0;
  logic [2:0]  req_op = '0;
  logic        req_ready, resp_valid, resp_err;
  logic [63:0] resp_rdata;
  exp_t        q[$];
  exp_t        e;
  logic [7:0]  ref_mem [BYTES];
  int          n_chk = 0, n_pass = 0, cyc = 0;
  bit          seen = 1'b0;
  dmem_responder #(.XLEN(64), .BASE_ADDR(BASE), .DEPTH(8192), .LATENCY(LAT)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_wr(req_wr), .req_op(req_op),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_rdata(resp_rdata), .resp_err(resp_err)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h want %h", name, act, exp);
  endtask
  // Byte-array reference: returns {err, data} and applies legal stores
  function automatic logic [64:0] model(input logic [63:0] a, input logic [63:0] wd, input logic wr, input logic [2:0] op);
    int          sz = 1 << op[1:0];
    int          o;
    logic [63:0] v = '0;
    if ((a % 64'(sz)) != 0 || a < BASE || a + 64'(sz) > BASE + 64'(BYTES) || op == 3'b111 || (wr && op[2]))
      return {1'b1, 64'd0};
    o = int'(a - BASE);
    for (int k = 0; k < sz; k++)
      if (wr) ref_mem[o+k] = wd[8*k +: 8];
      else v[8*k +: 8] = ref_mem[o+k];
    if (!wr && !op[2] && sz < 8 && v[8*sz-1]) v = v | (~64'd0 << (8*sz));
    return {1'b0, v};
  endfunction
  task automatic wait_idle();
    int n = 0;
    @(negedge clk);
    while (!req_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!req_ready) chk("idle_timeout", 64'(req_ready), 64'd1);
  endtask
  // Present one request; hand=1 uses the given expectation, discard=1 expects no response
  task automatic issue(input logic [63:0] a, input logic [63:0] wd, input logic wr, input logic [2:0] op,
                       input bit hand, input logic [63:0] hd, input logic he, input bit discard);
    logic [64:0] m;
    wait_idle();
    if (!req_ready) return;
    req_addr  = a;
    req_wdata = wd;
    req_wr    = wr;
    req_op    = op;
    req_valid = 1'b1;
    if (!discard) begin
      m = model(a, wd, wr, op);
      q.push_back(exp_t'{hand ? hd : m[63:0], hand ? he : m[64], cyc + 1});
    end
    @(negedge clk);
    req_valid = 1'b0;
  endtask
  // Monitor: latency on first sight of each response, data/err when it is consumed
  always @(negedge clk) begin
    if (!rst_n) seen = 1'b0;
    else if (resp_valid && q.size() == 0) chk("unexpected_resp", 64'(resp_valid), 64'd0);
    else if (resp_valid) begin
      if (!seen) begin
        seen = 1'b1;
        chk("latency", 64'(cyc - q[0].acc), 64'(LAT));
      end
      if (resp_ready) begin
        e = q.pop_front();
        chk("rdata", resp_rdata, e.data);
        chk("err", 64'(resp_err), 64'(e.err));
        seen = 1'b0;
      end
    end
  end
  initial begin
    int n;
    repeat (3) @(negedge clk);
    chk("rst_valid", 64'(resp_valid), 64'd0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_req_ready", 64'(req_ready), 64'd1);
    chk("rst_resp_valid", 64'(resp_valid), 64'd0);
    chk("rst_resp_rdata", resp_rdata, 64'd0);
    chk("rst_resp_err", 64'(resp_err), 64'd0);
    issue(BASE, 64'h1122334455667788, 1'b1, 3'b011, 1'b1, 64'd0, 1'b0, 1'b0);
    issue(BASE, 64'd0, 1'b0, 3'b011, 1'b1, 64'h1122334455667788, 1'b0, 1'b0);
    issue(BASE + 64'd3, 64'hAB, 1'b1, 3'b000, 1'b1, 64'd0, 1'b0, 1'b0);
    issue(BASE, 64'd0, 1'b0, 3'b011, 1'b1, 64'h11223344AB667788, 1'b0, 1'b0);
    issue(BASE + 64'd3, 64'd0, 1'b0, 3'b000, 1'b1, 64'hFFFFFFFFFFFFFFAB, 1'b0, 1'b0);
    issue(BASE + 64'd3, 64'd0, 1'b0, 3'b100, 1'b1, 64'h00000000000000AB, 1'b0, 1'b0);
    issue(BASE + 64'd1, 64'd0, 1'b0, 3'b001, 1'b1, 64'd0, 1'b1, 1'b0);
    issue(64'h7FFFFFFC, 64'd0, 1'b0, 3'b010, 1'b1, 64'd0, 1'b1, 1'b0);
    issue(BASE, 64'hFFFFFFFFFFFFFFFF, 1'b1, 3'b100, 1'b1, 64'd0, 1'b1, 1'b0);
    issue(BASE, 64'hFFFFFFFFFFFFFFFF, 1'b1, 3'b111, 1'b1, 64'd0, 1'b1, 1'b0);
    issue(BASE, 64'd0, 1'b0, 3'b111, 1'b1, 64'd0, 1'b1, 1'b0);
    issue(BASE, 64'd0, 1'b0, 3'b011, 1'b1, 64'h11223344AB667788, 1'b0, 1'b0);
    issue(BASE + 64'hFFFC, 64'hDEADBEEF, 1'b1, 3'b010, 1'b1, 64'd0, 1'b0, 1'b0);
    issue(BASE + 64'hFFFC, 64'd0, 1'b0, 3'b110, 1'b1, 64'h00000000DEADBEEF, 1'b0, 1'b0);
    issue(BASE + 64'hFFFC, 64'd0, 1'b0, 3'b010, 1'b1, 64'hFFFFFFFFDEADBEEF, 1'b0, 1'b0);
    issue(BASE + 64'hFFFE, 64'd0, 1'b0, 3'b001, 1'b1, 64'hFFFFFFFFFFFFDEAD, 1'b0, 1'b0);
    issue(BASE + 64'h10000, 64'd0, 1'b0, 3'b000, 1'b1, 64'd0, 1'b1, 1'b0);
    issue(BASE + 64'hFFFC, 64'd0, 1'b0, 3'b011, 1'b1, 64'd0, 1'b1, 1'b0);
    wait_idle();
    resp_ready = 1'b0;
    issue(BASE, 64'd0, 1'b0, 3'b011, 1'b1, 64'h11223344AB667788, 1'b0, 1'b0);
    n = 0;
    while (!resp_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    repeat (5) begin
      chk("hold_valid", 64'(resp_valid), 64'd1);
      chk("hold_rdata", resp_rdata, 64'h11223344AB667788);
      chk("hold_req_ready", 64'(req_ready), 64'd0);
      @(negedge clk);
    end
    @(posedge clk);
    #1 resp_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("release_req_ready", 64'(req_ready), 64'd1);
    issue(BASE + 64'h200, 64'hCAFEF00D12345678, 1'b1, 3'b011, 1'b1, 64'd0, 1'b0, 1'b0);
    issue(BASE + 64'h200, 64'h0BADBADBADBADBAD, 1'b1, 3'b011, 1'b0, 64'd0, 1'b0, 1'b1);
    @(negedge clk);
    rst_n = 1'b0;
    repeat (4) begin
      @(negedge clk);
      chk("mid_rst_valid", 64'(resp_valid), 64'd0);
    end
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst_req_ready", 64'(req_ready), 64'd1);
    issue(BASE + 64'h200, 64'd0, 1'b0, 3'b011, 1'b1, 64'hCAFEF00D12345678, 1'b0, 1'b0);
    for (int k = 0; k < 8; k++)
      issue(BASE + 64'h100 + 64'(8*k), {$urandom, $urandom}, 1'b1, 3'b011, 1'b0, 64'd0, 1'b0, 1'b0);
    for (int op = 0; op < 7; op++)
      for (int off = 0; off < 8; off++)
        for (int wr = 0; wr < 2; wr++)
          issue(BASE + 64'h100 + 64'($urandom_range(0, 7)) * 64'd8 + 64'(off), {$urandom, $urandom},
                wr[0], op[2:0], 1'b0, 64'd0, 1'b0, 1'b0);
    wait_idle();
    chk("queue_empty", 64'(q.size()), 64'd0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
